// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared widths, types and FSM encoding for the dispatch stage
package dispatch_pkg;

    localparam int DISPATCH_WIDTH = 4;
    localparam int IQ_NUM         = 3;
    localparam int IQ_WPORTS      = 2;
    localparam int IQ_SEL_W       = (IQ_NUM > 1) ? $clog2(IQ_NUM) : 1;
    // Port index / per-queue counter width; a counter can reach DISPATCH_WIDTH.
    localparam int PORT_IDX_W     = $clog2(DISPATCH_WIDTH + 1);

    typedef logic [IQ_SEL_W-1:0]   iq_sel_t;
    typedef logic [PORT_IDX_W-1:0] port_idx_t;
    typedef logic [31:0]           data_t;

    typedef struct packed {
        logic    valid;
        iq_sel_t sel;
        data_t   payload;
    } dispatch_slot_t;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/dispatch_port_alloc.sv
// rtl/dispatch_port_alloc.sv - in-order write-port allocation and fire mask for one group
module dispatch_port_alloc
    import dispatch_pkg::*;
(
    input  logic [DISPATCH_WIDTH-1:0]         pend,
    input  iq_sel_t [DISPATCH_WIDTH-1:0]      sel,
    input  logic [IQ_NUM-1:0][IQ_WPORTS-1:0]  ready,
    output port_idx_t [DISPATCH_WIDTH-1:0]    port_idx,
    output logic [DISPATCH_WIDTH-1:0]         fire
);

    port_idx_t cnt [IQ_NUM];
    logic      in_order;
    logic      port_ok;

    // Walk slots oldest first; each slot takes the next port of its queue and
    // fires only while every older pending slot has fired. An out-of-range
    // select matches no queue, so that slot never fires and blocks the rest.
    always_comb begin
        for (int q = 0; q < IQ_NUM; q++) begin
            cnt[q] = '0;
        end
        in_order = 1'b1;
        port_ok  = 1'b0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            fire[i]     = 1'b0;
            port_idx[i] = '0;
            for (int q = 0; q < IQ_NUM; q++) begin
                if (pend[i] && (sel[i] == IQ_SEL_W'(q))) begin
                    port_idx[i] = cnt[q];
                    port_ok     = 1'b0;
                    for (int p = 0; p < IQ_WPORTS; p++) begin
                        if ((cnt[q] == PORT_IDX_W'(p)) && ready[q][p]) begin
                            port_ok = 1'b1;
                        end
                    end
                    fire[i] = in_order && port_ok;
                    cnt[q]  = cnt[q] + PORT_IDX_W'(1);
                end
            end
            if (pend[i] && !fire[i]) begin
                in_order = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// rtl/dispatch_stage.sv - group register, handshake and flush in front of the issue queues
module dispatch_stage
    import dispatch_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_i,
    input  logic [DISPATCH_WIDTH-1:0]           rename_valid_i,
    output logic                                rename_ready_o,
    input  data_t [DISPATCH_WIDTH-1:0]          rename_data_i,
    input  iq_sel_t [DISPATCH_WIDTH-1:0]        rename_iq_sel_i,
    output logic [IQ_NUM-1:0][IQ_WPORTS-1:0]    iq_write_valid_o,
    input  logic [IQ_NUM-1:0][IQ_WPORTS-1:0]    iq_write_ready_i,
    output data_t [IQ_NUM-1:0][IQ_WPORTS-1:0]   iq_write_data_o,
    output logic [DISPATCH_WIDTH-1:0]           dispatch_fire_o,
    output logic                                busy_o
);

    state_t                            state_q;
    state_t                            state_d;
    dispatch_slot_t [DISPATCH_WIDTH-1:0] grp_q;
    logic [DISPATCH_WIDTH-1:0]         pend;
    iq_sel_t [DISPATCH_WIDTH-1:0]      grp_sel;
    port_idx_t [DISPATCH_WIDTH-1:0]    port_idx;
    logic [DISPATCH_WIDTH-1:0]         fire_raw;
    logic [DISPATCH_WIDTH-1:0]         fire_eff;
    logic [DISPATCH_WIDTH-1:0]         remain;
    logic                              all_fire;
    logic                              accept;

    // Unpack the registered group into the vectors the allocator consumes.
    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            pend[i]    = grp_q[i].valid;
            grp_sel[i] = grp_q[i].sel;
        end
    end

    dispatch_port_alloc u_alloc (
        .pend     (pend),
        .sel      (grp_sel),
        .ready    (iq_write_ready_i),
        .port_idx (port_idx),
        .fire     (fire_raw)
    );

    // FSM outputs: handshake, fire mask and busy; reset and flush suppress all firing.
    always_comb begin
        fire_eff        = (rst || flush_i) ? '0 : fire_raw;
        remain          = pend & ~fire_raw;
        all_fire        = (remain == '0);
        rename_ready_o  = !rst && !flush_i && ((state_q == ST_EMPTY) || all_fire);
        accept          = rename_ready_o && (|rename_valid_i);
        dispatch_fire_o = fire_eff;
        busy_o          = |pend;
    end

    // FSM next state: PENDING while any slot of the group is still waiting.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_PENDING;
        end else if (remain != '0) begin
            state_d = ST_PENDING;
        end else begin
            state_d = ST_EMPTY;
        end
    end

    // Route each firing slot onto its allocated queue write port.
    always_comb begin
        iq_write_valid_o = '0;
        iq_write_data_o  = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            for (int q = 0; q < IQ_NUM; q++) begin
                for (int p = 0; p < IQ_WPORTS; p++) begin
                    if (fire_eff[i] && (grp_q[i].sel == IQ_SEL_W'(q)) &&
                        (port_idx[i] == PORT_IDX_W'(p))) begin
                        iq_write_valid_o[q][p] = 1'b1;
                        iq_write_data_o[q][p]  = grp_q[i].payload;
                    end
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Group register: load a new group, retire fired slots, or drop everything on flush.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                grp_q[i].valid <= 1'b0;
            end
        end else if (accept) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                grp_q[i] <= {rename_valid_i[i], rename_iq_sel_i[i], rename_data_i[i]};
            end
        end else begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                grp_q[i].valid <= remain[i];
            end
        end
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb/tb_dispatch_stage.sv - directed self-checking bench for dispatch_stage
module tb_dispatch_stage;
    import dispatch_pkg::*;

    logic                             clk;
    logic                             rst;
    logic                             flush;
    logic [DISPATCH_WIDTH-1:0]        rv;
    logic                             ready;
    data_t [DISPATCH_WIDTH-1:0]       rd;
    iq_sel_t [DISPATCH_WIDTH-1:0]     rs;
    logic [IQ_NUM-1:0][IQ_WPORTS-1:0] wv;
    logic [IQ_NUM-1:0][IQ_WPORTS-1:0] wr;
    data_t [IQ_NUM-1:0][IQ_WPORTS-1:0] wd;
    logic [DISPATCH_WIDTH-1:0]        fire;
    logic                             busy;

    int compared;
    int mismatched;

    dispatch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush),
        .rename_valid_i   (rv),
        .rename_ready_o   (ready),
        .rename_data_i    (rd),
        .rename_iq_sel_i  (rs),
        .iq_write_valid_o (wv),
        .iq_write_ready_i (wr),
        .iq_write_data_o  (wd),
        .dispatch_fire_o  (fire),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any valid slot with a select beyond the last queue is a protocol error.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (rv[i]) begin
                    assert (int'(rs[i]) < IQ_NUM)
                    else $error("illegal iq select %0d on slot %0d", rs[i], i);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_group(input logic [3:0] mask, input iq_sel_t s0, input iq_sel_t s1,
                              input iq_sel_t s2, input iq_sel_t s3, input logic [31:0] base);
        rv    = mask;
        rs[0] = s0;
        rs[1] = s1;
        rs[2] = s2;
        rs[3] = s3;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            rd[i] = base + 32'(i);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        load_group(4'b1111, 2'd0, 2'd1, 2'd2, 2'd0, 32'h10);
        for (int c = 0; c < 2; c++) begin
            tick;
            compared++;
            if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b want 0", ready); end
            compared++;
            if (wv !== 6'b0) begin mismatched++; $display("FAIL reset_wv: got %b want 000000", wv); end
        end
        rst = 1'b0;
        rv  = 4'b0000;
        #1;
        compared++;
        if (ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_ready: got %b want 1", ready); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_full;
        load_group(4'b1111, 2'd0, 2'd1, 2'd2, 2'd0, 32'hA0);
        tick;
        load_group(4'b1111, 2'd1, 2'd1, 2'd2, 2'd2, 32'hB0);
        #1;
        compared++;
        if (fire !== 4'b1111) begin mismatched++; $display("FAIL full_fire: got %b want 1111", fire); end
        compared++;
        if (wv !== 6'b010111) begin mismatched++; $display("FAIL full_wv: got %b want 010111", wv); end
        compared++;
        if (wd[0][0] !== 32'hA0 || wd[0][1] !== 32'hA3 || wd[1][0] !== 32'hA1 || wd[2][0] !== 32'hA2) begin
            mismatched++;
            $display("FAIL full_data: got %h %h %h %h want a0 a3 a1 a2", wd[0][0], wd[0][1], wd[1][0], wd[2][0]);
        end
        compared++;
        if (ready !== 1'b1) begin mismatched++; $display("FAIL full_ready: got %b want 1", ready); end
        tick;
        rv = 4'b0000;
        #1;
        compared++;
        if (wv !== 6'b111100) begin mismatched++; $display("FAIL b2b_wv: got %b want 111100", wv); end
        compared++;
        if (wd[1][1] !== 32'hB1 || wd[2][1] !== 32'hB3) begin
            mismatched++;
            $display("FAIL b2b_data: got %h %h want b1 b3", wd[1][1], wd[2][1]);
        end
        tick;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL full_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow;
        load_group(4'b1111, 2'd0, 2'd0, 2'd0, 2'd1, 32'hC0);
        tick;
        rv = 4'b0000;
        #1;
        compared++;
        if (fire !== 4'b0011) begin mismatched++; $display("FAIL ovf_fire1: got %b want 0011", fire); end
        compared++;
        if (wv !== 6'b000011) begin mismatched++; $display("FAIL ovf_wv1: got %b want 000011", wv); end
        compared++;
        if (ready !== 1'b0) begin mismatched++; $display("FAIL ovf_ready1: got %b want 0", ready); end
        tick;
        compared++;
        if (fire !== 4'b1100) begin mismatched++; $display("FAIL ovf_fire2: got %b want 1100", fire); end
        compared++;
        if (wv !== 6'b000101) begin mismatched++; $display("FAIL ovf_wv2: got %b want 000101", wv); end
        compared++;
        if (wd[0][0] !== 32'hC2 || wd[1][0] !== 32'hC3) begin
            mismatched++;
            $display("FAIL ovf_data2: got %h %h want c2 c3", wd[0][0], wd[1][0]);
        end
        compared++;
        if (ready !== 1'b1) begin mismatched++; $display("FAIL ovf_ready2: got %b want 1", ready); end
        tick;
    endtask

    task automatic test_backpressure;
        load_group(4'b1111, 2'd0, 2'd1, 2'd2, 2'd0, 32'hD0);
        wr[1] = 2'b00;
        tick;
        rv = 4'b0000;
        #1;
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (fire !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
                mismatched++;
                $display("FAIL bp_fire c%0d: got %b want %b", c, fire, (c == 0) ? 4'b0001 : 4'b0000);
            end
            compared++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_busy_ready c%0d: got %b%b want 10", c, busy, ready);
            end
            tick;
        end
        wr = '1;
        #1;
        compared++;
        if (fire !== 4'b1110) begin mismatched++; $display("FAIL bp_drain_fire: got %b want 1110", fire); end
        compared++;
        if (wv !== 6'b010101) begin mismatched++; $display("FAIL bp_drain_wv: got %b want 010101", wv); end
        compared++;
        if (wd[0][0] !== 32'hD3 || wd[1][0] !== 32'hD1 || wd[2][0] !== 32'hD2) begin
            mismatched++;
            $display("FAIL bp_drain_data: got %h %h %h want d3 d1 d2", wd[0][0], wd[1][0], wd[2][0]);
        end
        tick;
    endtask

    task automatic test_inorder_block;
        load_group(4'b0011, 2'd0, 2'd1, 2'd0, 2'd0, 32'h50);
        wr[0] = 2'b00;
        tick;
        rv = 4'b0000;
        #1;
        compared++;
        if (fire !== 4'b0000 || wv !== 6'b0) begin
            mismatched++;
            $display("FAIL inorder_block: got fire %b wv %b want 0000 000000", fire, wv);
        end
        wr = '1;
        #1;
        compared++;
        if (fire !== 4'b0011) begin mismatched++; $display("FAIL inorder_release: got %b want 0011", fire); end
        tick;
    endtask

    task automatic test_flush;
        load_group(4'b1111, 2'd0, 2'd0, 2'd0, 2'd0, 32'hF0);
        tick;
        rv = 4'b0000;
        #1;
        compared++;
        if (fire !== 4'b0011) begin mismatched++; $display("FAIL flush_pre_fire: got %b want 0011", fire); end
        tick;
        flush = 1'b1;
        load_group(4'b1111, 2'd1, 2'd1, 2'd1, 2'd1, 32'hE0);
        #1;
        compared++;
        if (wv !== 6'b0 || fire !== 4'b0000) begin
            mismatched++;
            $display("FAIL flush_cycle: got wv %b fire %b want 000000 0000", wv, fire);
        end
        compared++;
        if (ready !== 1'b0) begin mismatched++; $display("FAIL flush_ready: got %b want 0", ready); end
        tick;
        flush = 1'b0;
        rv    = 4'b0000;
        #1;
        compared++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_after: got busy %b ready %b want 0 1", busy, ready);
        end
        compared++;
        if (wv !== 6'b0) begin mismatched++; $display("FAIL flush_stale: got %b want 000000", wv); end
        tick;
        compared++;
        if (wv !== 6'b0) begin mismatched++; $display("FAIL flush_stale2: got %b want 000000", wv); end
    endtask

    task automatic test_sparse;
        load_group(4'b1010, 2'd0, 2'd2, 2'd0, 2'd2, 32'h70);
        tick;
        rv = 4'b0000;
        #1;
        compared++;
        if (fire !== 4'b1010) begin mismatched++; $display("FAIL sparse_fire: got %b want 1010", fire); end
        compared++;
        if (wv !== 6'b110000) begin mismatched++; $display("FAIL sparse_wv: got %b want 110000", wv); end
        compared++;
        if (wd[2][0] !== 32'h71 || wd[2][1] !== 32'h73) begin
            mismatched++;
            $display("FAIL sparse_data: got %h %h want 71 73", wd[2][0], wd[2][1]);
        end
        tick;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL sparse_idle: got %b want 0", busy); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        rv         = '0;
        rs         = '0;
        rd         = '0;
        wr         = '1;
        test_reset;
        test_full;
        test_overflow;
        test_backpressure;
        test_inorder_block;
        test_flush;
        test_sparse;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
